// File: rtl/scan_pkg.sv
// Shared constants and types for the LED scan sequencer family.
// Mode encodings, index bounds and the index/direction state record.
package scan_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  localparam logic [2:0] IDX_MAX  = 3'd7;
  localparam logic       DIR_UP   = 1'b0;
  localparam logic       DIR_DOWN = 1'b1;

  typedef struct packed {
    logic [2:0] idx;
    logic       dir;
  } scan_state_t;

endpackage

// File: rtl/led_scan_sequencer_tick_prescaler.sv
// Free-running divider: Tc is high combinationally in the terminal-count cycle.
// En low freezes the count in place; Clr restarts the period from 0.
module tick_prescaler #(
  parameter int CNT_MAX = 25_000_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic En,
  input  logic Clr,
  output logic Tc
);

  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CNT_MAX - 1);

  logic [CNT_W-1:0] cnt;

  // Gated by En so a count frozen at the terminal value cannot fire repeatedly.
  assign Tc = En && (cnt == TC_VAL);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (Clr || Tc) begin
      cnt <= '0;
    end else if (En) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_scan_sequencer.sv
// Drives the 3-bit decoder select, stepping up/down/ping-pong on prescaler or Step.
// Outputs update on the edge that consumes an advance; Tick flags that first cycle.
module led_scan_sequencer
  import scan_pkg::*;
#(
  parameter int CNT_MAX = 25_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  input  logic [1:0] Mode,
  input  logic       Step,
  output logic       A0,
  output logic       A1,
  output logic       A2,
  output logic       Dir,
  output logic       Tick
);

  mode_e       mode;
  logic        hold;
  logic        adv_auto;
  logic        adv;
  scan_state_t cur;
  scan_state_t nxt;
  logic        tick_q;

  assign mode = mode_e'(Mode);
  assign hold = (mode == MODE_HOLD);
  assign adv  = (adv_auto | Step) & ~hold;

  tick_prescaler #(
    .CNT_MAX(CNT_MAX)
  ) u_prescaler (
    .Clk  (Clk),
    .Reset(Reset),
    .En   (En & ~hold),
    .Clr  (Step & ~hold),
    .Tc   (adv_auto)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur    <= '{idx: 3'd0, dir: DIR_UP};
      tick_q <= 1'b0;
    end else begin
      cur    <= nxt;
      tick_q <= adv;
    end
  end

  always_comb begin
    nxt = cur;
    if (adv) begin
      case (mode)
        MODE_UP: begin
          nxt.idx = cur.idx + 3'd1;
          nxt.dir = DIR_UP;
        end
        MODE_DOWN: begin
          nxt.idx = cur.idx - 3'd1;
          nxt.dir = DIR_DOWN;
        end
        MODE_PINGPONG: begin
          // Turn at the ends without repeating the end point.
          if (cur.dir == DIR_UP) begin
            if (cur.idx == IDX_MAX) begin
              nxt.idx = IDX_MAX - 3'd1;
              nxt.dir = DIR_DOWN;
            end else begin
              nxt.idx = cur.idx + 3'd1;
            end
          end else begin
            if (cur.idx == 3'd0) begin
              nxt.idx = 3'd1;
              nxt.dir = DIR_UP;
            end else begin
              nxt.idx = cur.idx - 3'd1;
            end
          end
        end
        default: nxt = cur;
      endcase
    end
  end

  always_comb begin
    {A2, A1, A0} = cur.idx;
    Dir          = cur.dir;
    Tick         = tick_q;
  end

endmodule
